// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, through a single fulladder
// cell with the carry held in a flip-flop between cycles.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_axb;

  assign w_axb = a ^ b;
  assign s     = w_axb ^ ci;
  assign co    = (a & b) | (ci & w_axb);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;

  fulladder u_fa (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= c_in;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_carry  <= w_co;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum_sh;
  assign c_out     = r_carry;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16,
// with a queue of expected {c_out,sum} values pushed at accept time.

module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic        c_in;

  logic        iv8, ir8, ov8, or8, co8;
  logic [7:0]  sum8;
  logic        iv16, ir16, ov16, or16, co16;
  logic [15:0] sum16;

  logic [32:0] sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          accepts  = 0;
  int          results  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a_drv[7:0]),
    .b         (b_drv[7:0]),
    .c_in      (c_in),
    .out_valid (ov8),
    .out_ready (or8),
    .sum       (sum8),
    .c_out     (co8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a_drv[15:0]),
    .b         (b_drv[15:0]),
    .c_in      (c_in),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (sum16),
    .c_out     (co16)
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input bit sel, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci);
    if (sel) return 33'(x[15:0]) + 33'(y[15:0]) + 33'(ci);
    return 33'(x[7:0]) + 33'(y[7:0]) + 33'(ci);
  endfunction

  function automatic logic get_ir(input bit sel);
    return sel ? ir16 : ir8;
  endfunction

  function automatic logic get_ov(input bit sel);
    return sel ? ov16 : ov8;
  endfunction

  function automatic logic [32:0] get_res(input bit sel);
    return sel ? {16'b0, co16, sum16} : {24'b0, co8, sum8};
  endfunction

  task automatic set_iv(input bit sel, input logic v);
    if (sel) iv16 = v; else iv8 = v;
  endtask

  task automatic set_or(input bit sel, input logic v);
    if (sel) or16 = v; else or8 = v;
  endtask

  // One full transaction; inputs change on negedges, outputs sampled on negedges.
  task automatic do_op(input bit sel, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input int stall, input bit disturb, input bit chk_lat);
    int          n;
    int          w;
    logic [32:0] held;
    logic [32:0] exp;
    w = sel ? 16 : 8;
    @(negedge clk);
    n = 0;
    while (!get_ir(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("in_ready_timeout", 33'(get_ir(sel)), 33'(1));
      return;
    end
    a_drv = x;
    b_drv = y;
    c_in  = ci;
    set_iv(sel, 1'b1);
    set_or(sel, (stall == 0) ? 1'b1 : 1'b0);
    @(posedge clk);
    sb.push_back(model(sel, x, y, ci));
    accepts++;
    @(negedge clk);
    set_iv(sel, 1'b0);
    a_drv = $urandom;
    b_drv = $urandom;
    n = 1;
    if (disturb) begin
      a_drv = ~x;
      b_drv = x ^ 32'h0000_00A5;
      c_in  = ~ci;
      set_iv(sel, 1'b1);
      @(negedge clk);
      n++;
      set_iv(sel, 1'b0);
    end
    while (!get_ov(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!get_ov(sel)) begin
      check("out_valid_timeout", 33'(get_ov(sel)), 33'(1));
      return;
    end
    if (chk_lat) check("latency", 33'(n), 33'(w + 1));
    held = get_res(sel);
    for (int i = 0; i < stall; i++) begin
      check("stall_in_ready", 33'(get_ir(sel)), 33'(0));
      check("stall_out_valid", 33'(get_ov(sel)), 33'(1));
      check("stall_result", get_res(sel), held);
      @(negedge clk);
    end
    set_or(sel, 1'b1);
    if (sb.size() == 0) begin
      check("sb_underflow", 33'(sb.size()), 33'(1));
    end else begin
      exp = sb.pop_front();
      check(sel ? "result16" : "result8", get_res(sel), exp);
      results++;
    end
    @(negedge clk);
    check("post_out_valid", 33'(get_ov(sel)), 33'(0));
    check("post_in_ready", 33'(get_ir(sel)), 33'(1));
    set_or(sel, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_drv = '0;
    b_drv = '0;
    c_in  = 1'b0;
    iv8   = 1'b0;
    or8   = 1'b0;
    iv16  = 1'b0;
    or16  = 1'b0;
    #2;
    check("rst_in_ready", 33'(ir8), 33'(1));
    check("rst_out_valid", 33'(ov8), 33'(0));
    check("rst_sum_cout", {24'b0, co8, sum8}, 33'(0));
    check("rst_in_ready16", 33'(ir16), 33'(1));
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 32'h5A, 32'h3C, 1'b0, 0, 1'b0, 1'b1);
    do_op(1'b0, 32'hFF, 32'h01, 1'b0, 0, 1'b0, 1'b1);
    do_op(1'b0, 32'hFF, 32'h00, 1'b1, 0, 1'b0, 1'b0);
    do_op(1'b0, 32'h00, 32'h00, 1'b1, 0, 1'b0, 1'b0);
    do_op(1'b0, 32'hC3, 32'h7E, 1'b1, 5, 1'b0, 1'b1);
    do_op(1'b0, 32'h81, 32'h42, 1'b0, 0, 1'b1, 1'b1);
    do_op(1'b1, 32'hFFFF, 32'h0001, 1'b1, 2, 1'b0, 1'b1);

    // Asynchronous reset in the middle of RUN, with the counter at 3.
    @(negedge clk);
    a_drv = 32'hFF;
    b_drv = 32'h01;
    c_in  = 1'b1;
    iv8   = 1'b1;
    or8   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_in_ready", 33'(ir8), 33'(0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 33'(ir8), 33'(1));
    check("arst_out_valid", 33'(ov8), 33'(0));
    check("arst_sum", 33'(sum8), 33'(0));
    check("arst_c_out", 33'(co8), 33'(0));
    @(negedge clk);
    rst_n = 1'b1;
    or8   = 1'b0;
    do_op(1'b0, 32'h12, 32'h34, 1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      do_op(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      do_op(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0, 1'b0);
    end

    check("accepts_vs_results", 33'(accepts), 33'(results));
    check("sb_empty", 33'(sb.size()), 33'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
